riscv_test_checker: RTL and testbench
=====================================

Name: riscv_test_checker

Overview:
- Synthesizable self-check engine for the RISC-V core bench.
- Holds a loadable table of NUM_TEST expected (instruction-count, output-value) pairs.
- Compares the core's OUTPUT_PORT each time NUM_INST reaches the next table entry, and reports pass/fail/timeout status through registered outputs.
- Sits beside RISCV_TOP, sampling NUM_INST, OUTPUT_PORT and HALT; replaces per-bench hand-written check loops.

Parameters:
- NUM_TEST, 32, table depth (entries)
- IDX_W, 5, index width, clog2(NUM_TEST)
- DWIDTH, 32, width of NUM_INST, OUTPUT_PORT and expected answer
- CYC_W, 32, cycle counter width
- TIMEOUT, 1000000, cycles in RUN before TIMEOUT state

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- LOAD_EN  in  1  write one table entry this cycle (accepted only in IDLE)
- LOAD_IDX  in  IDX_W  entry index
- LOAD_NINST  in  DWIDTH  expected NUM_INST for entry
- LOAD_ANS  in  DWIDTH  expected OUTPUT_PORT for entry
- LOAD_MASK  in  DWIDTH  compare mask (used only with CHK_MASK_EN)
- NUM_VALID  in  IDX_W+1  number of loaded entries, sampled on START
- START  in  1  IDLE->RUN
- NUM_INST  in  DWIDTH  retired-instruction count from core
- OUTPUT_PORT  in  DWIDTH  core output port
- HALT  in  1  core halt
- STATE  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT
- DONE  out  1  STATE is PASS, FAIL or TIMEOUT
- PASS_CNT  out  IDX_W+1  entries passed
- FAIL_IDX  out  IDX_W  index of first failing entry
- FAIL_VAL  out  DWIDTH  OUTPUT_PORT captured at first failure
- CYCLE  out  CYC_W  cycles spent in RUN

Behaviour:
- Reset: STATE=IDLE; DONE=0, PASS_CNT=0, FAIL_IDX=0, FAIL_VAL=0, CYCLE=0; pointer ptr=0.
- Table contents are not reset.
- RST mid-RUN aborts the run and returns to IDLE with all outputs cleared.
- IDLE:
  - LOAD_EN writes entry[LOAD_IDX]; it is ignored in every other state.
  - START latches NUM_VALID into nv and clears the counters.
  - If nv==0: go to PASS next cycle. Otherwise go to RUN.
- RUN:
  - CYCLE increments every cycle and saturates at all-ones.
  - Only entry[ptr] is examined.
  - Entries must be loaded with strictly ascending NINST.
- Per-cycle priority in RUN, highest first:
  1. NUM_INST == entry[ptr].NINST and OUTPUT_PORT matches ANS: PASS_CNT+1, ptr+1. If ptr+1 == nv, go to PASS.
  2. NUM_INST == entry[ptr].NINST and OUTPUT_PORT mismatches: FAIL; FAIL_IDX=ptr, FAIL_VAL=OUTPUT_PORT.
  3. NUM_INST > entry[ptr].NINST (count skipped past the entry): FAIL; FAIL_IDX=ptr, FAIL_VAL=OUTPUT_PORT.
  4. HALT=1 with ptr<nv: FAIL; FAIL_IDX=ptr, FAIL_VAL=OUTPUT_PORT.
  5. CYCLE == TIMEOUT-1: TIMEOUT.
- A match on the same cycle as HALT is evaluated first; if it completes the table, the result is PASS.
- Comparisons are unsigned and DWIDTH wide.
- NUM_INST held constant over several cycles checks an entry only once, because ptr has advanced.
- PASS, FAIL and TIMEOUT are sticky until RST. START is ignored there. Outputs hold.
- All outputs are registered; STATE changes on the clock edge after the deciding sample (latency 1).

Optional Feature:
- Macro: CHK_MASK_EN.
- Defined: each entry also stores MASK; the match test is (OUTPUT_PORT & MASK) == (ANS & MASK).
- Defined: LOAD_MASK is written alongside the other entry fields.
- Undefined: full-width equality; no MASK storage; LOAD_MASK is ignored.

Test Plan:
- All pass: load entries (1,5), (2,0), (3,1); nv=3; drive NUM_INST 1,2,3 with OUTPUT_PORT 5,0,1 -> PASS_CNT=3, STATE=PASS one cycle after NUM_INST=3.
- Mismatch: same table; OUTPUT_PORT=7 at NUM_INST=2 -> STATE=FAIL, FAIL_IDX=1, FAIL_VAL=7, PASS_CNT=1.
- Skip: entries (1,5), (3,1); NUM_INST goes 1 then 4 -> FAIL, FAIL_IDX=1.
- Early halt and timeout:
  - Table (1,5), (9,2); HALT after NUM_INST=1 -> FAIL, FAIL_IDX=1.
  - TIMEOUT=16 with NUM_INST stuck at 0 -> STATE=TIMEOUT, CYCLE=16.
- Reset mid-run and hold: RST asserted during RUN -> IDLE, counters 0, table retained; re-START -> passes. NUM_INST held at 1 for 5 cycles -> PASS_CNT increments once.
- CHK_MASK_EN: entry (1, ANS=0x12, MASK=0x0F); OUTPUT_PORT=0xF2 -> pass. Without the macro -> FAIL, FAIL_VAL=0xF2.

Source files
------------

// File: rtl/riscv_test_checker.sv
// riscv_test_checker: table-driven pass/fail/timeout checker sitting beside RISCV_TOP.
// Optional macro CHK_MASK_EN adds a per-entry compare mask loaded through LOAD_MASK.
module riscv_test_checker #(
  parameter int NUM_TEST = 32,
  parameter int IDX_W    = 5,
  parameter int DWIDTH   = 32,
  parameter int CYC_W    = 32,
  parameter int TIMEOUT  = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD_EN,
  input  logic [IDX_W-1:0]  LOAD_IDX,
  input  logic [DWIDTH-1:0] LOAD_NINST,
  input  logic [DWIDTH-1:0] LOAD_ANS,
  input  logic [DWIDTH-1:0] LOAD_MASK,
  input  logic [IDX_W:0]    NUM_VALID,
  input  logic              START,
  input  logic [DWIDTH-1:0] NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic [2:0]        STATE,
  output logic              DONE,
  output logic [IDX_W:0]    PASS_CNT,
  output logic [IDX_W-1:0]  FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_VAL,
  output logic [CYC_W-1:0]  CYCLE
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RUN = 3'd1, S_PASS = 3'd2, S_FAIL = 3'd3, S_TIMEOUT = 3'd4
  } state_t;

  typedef struct packed {
`ifdef CHK_MASK_EN
    logic [DWIDTH-1:0] mask;
`endif
    logic [DWIDTH-1:0] ninst;
    logic [DWIDTH-1:0] ans;
  } entry_t;

  entry_t            r_tab [NUM_TEST];
  state_t            r_state, w_state_nxt;
  logic [IDX_W:0]    r_ptr, w_ptr_nxt, r_nv, w_nv_nxt;
  logic [CYC_W-1:0]  r_cycle, w_cycle_nxt;
  logic [IDX_W-1:0]  r_fidx, w_fidx_nxt;
  logic [DWIDTH-1:0] r_fval, w_fval_nxt;
  logic              r_done;
  entry_t            w_ent;
  logic              w_hit, w_past, w_ok;

  assign w_ent  = r_tab[r_ptr[IDX_W-1:0]];
  assign w_hit  = (NUM_INST == w_ent.ninst);
  assign w_past = (NUM_INST > w_ent.ninst);
`ifdef CHK_MASK_EN
  assign w_ok   = ((OUTPUT_PORT ^ w_ent.ans) & w_ent.mask) == '0;
`else
  assign w_ok   = (OUTPUT_PORT == w_ent.ans);
  logic w_unused_mask;
  assign w_unused_mask = ^LOAD_MASK;
`endif

  // Table has no reset so a re-run after RST reuses the loaded entries.
  always_ff @(posedge CLK) begin
    if (!RST && LOAD_EN && r_state == S_IDLE) begin
      r_tab[LOAD_IDX].ninst <= LOAD_NINST;
      r_tab[LOAD_IDX].ans   <= LOAD_ANS;
`ifdef CHK_MASK_EN
      r_tab[LOAD_IDX].mask  <= LOAD_MASK;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_nv_nxt    = r_nv;
    w_cycle_nxt = r_cycle;
    w_fidx_nxt  = r_fidx;
    w_fval_nxt  = r_fval;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_nv_nxt    = NUM_VALID;
          w_ptr_nxt   = '0;
          w_cycle_nxt = '0;
          w_fidx_nxt  = '0;
          w_fval_nxt  = '0;
          w_state_nxt = (NUM_VALID == '0) ? S_PASS : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cycle != '1) w_cycle_nxt = r_cycle + 1'b1;
        // A match outranks HALT, so a halt on the final matching sample still passes.
        if (w_hit && w_ok) begin
          w_ptr_nxt = r_ptr + 1'b1;
          if ((r_ptr + 1'b1) == r_nv) w_state_nxt = S_PASS;
        end else if (w_hit || w_past || HALT) begin
          w_state_nxt = S_FAIL;
          w_fidx_nxt  = r_ptr[IDX_W-1:0];
          w_fval_nxt  = OUTPUT_PORT;
        end else if (r_cycle == CYC_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_nv    <= '0;
      r_cycle <= '0;
      r_fidx  <= '0;
      r_fval  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_nv    <= w_nv_nxt;
      r_cycle <= w_cycle_nxt;
      r_fidx  <= w_fidx_nxt;
      r_fval  <= w_fval_nxt;
      r_done  <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL) ||
                 (w_state_nxt == S_TIMEOUT);
    end
  end

  // PASS_CNT tracks ptr exactly: ptr only advances on a passing entry.
  assign STATE    = r_state;
  assign DONE     = r_done;
  assign PASS_CNT = r_ptr;
  assign FAIL_IDX = r_fidx;
  assign FAIL_VAL = r_fval;
  assign CYCLE    = r_cycle;
endmodule

// File: tb/tb_riscv_test_checker.sv
// Bench for riscv_test_checker: directed test-plan cases plus random traces against a trace-walking model.
module tb_riscv_test_checker;
  localparam int TO = 16;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PASS = 2, ST_FAIL = 3, ST_TO = 4;

  logic        CLK = 0;
  logic        RST = 0, LOAD_EN = 0, START = 0, HALT = 0;
  logic [4:0]  LOAD_IDX = 0;
  logic [31:0] LOAD_NINST = 0, LOAD_ANS = 0, LOAD_MASK = 0;
  logic [5:0]  NUM_VALID = 0;
  logic [31:0] NUM_INST = 0, OUTPUT_PORT = 0;
  logic [2:0]  STATE;
  logic        DONE;
  logic [5:0]  PASS_CNT;
  logic [4:0]  FAIL_IDX;
  logic [31:0] FAIL_VAL, CYCLE;

  riscv_test_checker #(.NUM_TEST(32), .IDX_W(5), .DWIDTH(32), .CYC_W(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_IDX(LOAD_IDX), .LOAD_NINST(LOAD_NINST),
    .LOAD_ANS(LOAD_ANS), .LOAD_MASK(LOAD_MASK), .NUM_VALID(NUM_VALID), .START(START),
    .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .STATE(STATE), .DONE(DONE),
    .PASS_CNT(PASS_CNT), .FAIL_IDX(FAIL_IDX), .FAIL_VAL(FAIL_VAL), .CYCLE(CYCLE));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  logic [31:0] tab_n [32], tab_a [32], tab_m [32];
  logic [31:0] tr_n [64], tr_o [64];
  bit          tr_h [64];
  int          exp_st [64], exp_pc [64], exp_cyc [64];
  int          exp_fidx;
  logic [31:0] exp_fval;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit match(input logic [31:0] o, input logic [31:0] a, input logic [31:0] m);
`ifdef CHK_MASK_EN
    return (o & m) == (a & m);
`else
    return o == a;
`endif
  endfunction

  // Walk the trace: each sample either completes the current entry, kills the run, or waits.
  task automatic model(input int nv, input int len);
    int st, ptr, cyc;
    st = ST_RUN; ptr = 0; cyc = 0; exp_fidx = 0; exp_fval = 0;
    for (int k = 0; k < len; k++) begin
      if (st == ST_RUN) begin
        if (tr_n[k] == tab_n[ptr] && match(tr_o[k], tab_a[ptr], tab_m[ptr])) begin
          ptr++;
          if (ptr == nv) st = ST_PASS;
        end else if (tr_n[k] >= tab_n[ptr] || tr_h[k]) begin
          st = ST_FAIL; exp_fidx = ptr; exp_fval = tr_o[k];
        end else if (cyc + 1 == TO) begin
          st = ST_TO;
        end
        cyc++;
      end
      exp_st[k] = st; exp_pc[k] = ptr; exp_cyc[k] = cyc;
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1; START = 0; LOAD_EN = 0; HALT = 0; NUM_INST = 0;
    tick();
    RST = 0;
    chk("rst_state", STATE, ST_IDLE);
    chk("rst_done", DONE, 0);
    chk("rst_pcnt", PASS_CNT, 0);
    chk("rst_fidx", FAIL_IDX, 0);
    chk("rst_fval", FAIL_VAL, 0);
    chk("rst_cycle", CYCLE, 0);
  endtask

  task automatic load(input int nv);
    for (int i = 0; i < nv; i++) begin
      LOAD_EN = 1; LOAD_IDX = 5'(i);
      LOAD_NINST = tab_n[i]; LOAD_ANS = tab_a[i]; LOAD_MASK = tab_m[i];
      tick();
    end
    LOAD_EN = 0;
  endtask

  task automatic run(input int nv, input int len);
    int fin;
    if (nv > 0) model(nv, len);
    NUM_VALID = 6'(nv); START = 1;
    tick();
    START = 0;
    chk("start_state", STATE, (nv == 0) ? ST_PASS : ST_RUN);
    chk("start_cycle", CYCLE, 0);
    for (int k = 0; k < len; k++) begin
      NUM_INST = tr_n[k]; OUTPUT_PORT = tr_o[k]; HALT = tr_h[k];
      tick();
      if (nv > 0) begin
        chk("run_state", STATE, exp_st[k]);
        chk("run_pcnt", PASS_CNT, exp_pc[k]);
        chk("run_cycle", CYCLE, exp_cyc[k]);
        chk("run_done", DONE, exp_st[k] != ST_RUN);
      end else begin
        chk("nv0_state", STATE, ST_PASS);
      end
    end
    HALT = 0;
    fin = (nv > 0) ? exp_st[len-1] : ST_PASS;
    chk("end_done", DONE, fin != ST_RUN);
    chk("end_fidx", FAIL_IDX, (nv > 0) ? exp_fidx : 0);
    chk("end_fval", FAIL_VAL, (nv > 0) ? exp_fval : 0);
  endtask

  task automatic set_tab(input int i, input logic [31:0] n, input logic [31:0] a);
    tab_n[i] = n; tab_a[i] = a; tab_m[i] = 32'hFFFF_FFFF;
  endtask

  task automatic set_tr(input int k, input logic [31:0] n, input logic [31:0] o, input bit h);
    tr_n[k] = n; tr_o[k] = o; tr_h[k] = h;
  endtask

  initial begin
    // All pass
    do_reset();
    set_tab(0, 1, 5); set_tab(1, 2, 0); set_tab(2, 3, 1);
    load(3);
    set_tr(0, 1, 5, 0); set_tr(1, 2, 0, 0); set_tr(2, 3, 1, 0);
    run(3, 3);
    chk("allpass_state", STATE, ST_PASS);
    chk("allpass_pcnt", PASS_CNT, 3);

    // Sticky PASS: START and LOAD_EN ignored; a leaked load would break the next rerun
    LOAD_EN = 1; LOAD_IDX = 0; LOAD_NINST = 1; LOAD_ANS = 99; START = 1; NUM_VALID = 0;
    tick(); tick();
    LOAD_EN = 0; START = 0;
    chk("sticky_state", STATE, ST_PASS);
    chk("sticky_cycle", CYCLE, 3);
    chk("sticky_pcnt", PASS_CNT, 3);

    // Reset mid-run, table retained, then rerun passes
    do_reset();
    NUM_VALID = 3; START = 1; tick(); START = 0;
    NUM_INST = 1; OUTPUT_PORT = 5; tick();
    chk("midrun_pcnt", PASS_CNT, 1);
    do_reset();
    run(3, 3);
    chk("rerun_state", STATE, ST_PASS);

    // Mismatch at entry 1
    do_reset();
    set_tr(0, 1, 5, 0); set_tr(1, 2, 7, 0);
    run(3, 2);
    chk("mism_state", STATE, ST_FAIL);
    chk("mism_fidx", FAIL_IDX, 1);
    chk("mism_fval", FAIL_VAL, 7);
    chk("mism_pcnt", PASS_CNT, 1);

    // NUM_INST held at 1 for five cycles checks entry 0 once
    do_reset();
    for (int k = 0; k < 5; k++) set_tr(k, 1, 5, 0);
    set_tr(5, 2, 0, 0); set_tr(6, 3, 1, 0);
    run(3, 7);
    chk("hold_state", STATE, ST_PASS);
    chk("hold_pcnt", PASS_CNT, 3);
    chk("hold_cycle", CYCLE, 7);

    // Skip past entry 1
    do_reset();
    set_tab(0, 1, 5); set_tab(1, 3, 1);
    load(2);
    set_tr(0, 1, 5, 0); set_tr(1, 4, 9, 0);
    run(2, 2);
    chk("skip_state", STATE, ST_FAIL);
    chk("skip_fidx", FAIL_IDX, 1);
    chk("skip_fval", FAIL_VAL, 9);

    // Early halt
    do_reset();
    set_tab(0, 1, 5); set_tab(1, 9, 2);
    load(2);
    set_tr(0, 1, 5, 0); set_tr(1, 2, 4, 1);
    run(2, 2);
    chk("halt_state", STATE, ST_FAIL);
    chk("halt_fidx", FAIL_IDX, 1);

    // Halt on the completing match still passes
    do_reset();
    set_tab(0, 1, 5); set_tab(1, 2, 6);
    load(2);
    set_tr(0, 1, 5, 0); set_tr(1, 2, 6, 1);
    run(2, 2);
    chk("halt_match_state", STATE, ST_PASS);

    // Timeout with NUM_INST stuck at 0
    do_reset();
    set_tab(0, 1, 5);
    load(1);
    for (int k = 0; k < 20; k++) set_tr(k, 0, 0, 0);
    run(1, 20);
    chk("to_state", STATE, ST_TO);
    chk("to_cycle", CYCLE, TO);

    // Empty table passes at once
    do_reset();
    set_tr(0, 0, 0, 1);
    run(0, 1);
    chk("nv0_pcnt", PASS_CNT, 0);

    // Unsigned compare across bit 31
    do_reset();
    set_tab(0, 32'h8000_0000, 3);
    load(1);
    set_tr(0, 32'h7FFF_FFFF, 0, 0); set_tr(1, 32'h8000_0000, 3, 0);
    run(1, 2);
    chk("unsigned_state", STATE, ST_PASS);

    // Masked compare
    do_reset();
    tab_n[0] = 1; tab_a[0] = 32'h12; tab_m[0] = 32'h0F;
    load(1);
    set_tr(0, 1, 32'hF2, 0);
    run(1, 1);
`ifdef CHK_MASK_EN
    chk("mask_state", STATE, ST_PASS);
`else
    chk("mask_state", STATE, ST_FAIL);
    chk("mask_fval", FAIL_VAL, 32'hF2);
`endif

    // Random tables and traces
    for (int t = 0; t < 40; t++) begin
      int nv;
      logic [31:0] ni;
      do_reset();
      nv = $urandom_range(1, 6);
      for (int i = 0; i < nv; i++) begin
        tab_n[i] = (i == 0) ? 32'($urandom_range(1, 3)) : tab_n[i-1] + 32'($urandom_range(1, 3));
        tab_a[i] = $urandom;
        tab_m[i] = $urandom;
      end
      load(nv);
      ni = 0;
      for (int k = 0; k < 18; k++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) ni = ni + 2;
        else if (r < 12) ni = ni + 1;
        tr_n[k] = ni;
        tr_o[k] = $urandom;
        for (int i = 0; i < nv; i++)
          if (tab_n[i] == ni && $urandom_range(0, 9) != 0) tr_o[k] = tab_a[i];
        tr_h[k] = ($urandom_range(0, 29) == 0);
      end
      run(nv, 18);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
